// File: rtl/redundant_pkg.sv
// Shared defaults and FSM state type for the redundant-to-binary normalizer.
// Imported by redundant_normalizer and carry_resolve_chunk.
package redundant_pkg;

  localparam int NUM_DIGITS_DEF = 130;
  localparam int DIGIT_BITS_DEF = 16;
  localparam int REDUN_BITS_DEF = 19;
  localparam int DPC_DEF        = 10;

  // Worst-case inter-digit carry is 16, which fits in 5 bits.
  localparam int CARRY_BITS     = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/carry_resolve_chunk.sv
// Combinational ripple over DPC carry-save digit pairs plus carry-in.
// Ports: c, s (digit halves), carry_in -> digits (16-bit each), carry_out.
module carry_resolve_chunk
  import redundant_pkg::*;
#(
  parameter int DPC        = DPC_DEF,
  parameter int DIGIT_BITS = DIGIT_BITS_DEF,
  parameter int REDUN_BITS = REDUN_BITS_DEF
) (
  input  logic [DPC-1:0][REDUN_BITS-1:0] c,
  input  logic [DPC-1:0][REDUN_BITS-1:0] s,
  input  logic [CARRY_BITS-1:0]          carry_in,
  output logic [DPC-1:0][DIGIT_BITS-1:0] digits,
  output logic [CARRY_BITS-1:0]          carry_out
);

  localparam int TW = DIGIT_BITS + CARRY_BITS;

  always_comb begin : ripple
    logic [CARRY_BITS-1:0] cy;
    logic [TW-1:0]         t;
    cy     = carry_in;
    t      = '0;
    digits = '0;
    for (int i = 0; i < DPC; i++) begin
      t         = TW'(c[i]) + TW'(s[i]) + TW'(cy);
      digits[i] = t[DIGIT_BITS-1:0];
      cy        = t[TW-1:DIGIT_BITS];
    end
    carry_out = cy;
  end

endmodule

// File: rtl/redundant_normalizer.sv
// Converts a carry-save operand (C+S per digit) into plain 16-bit digits,
// resolving DIGITS_PER_CYCLE digits per RUN cycle.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with C, S;
// out_valid/out_ready with out_digits and out_carry.
module redundant_normalizer
  import redundant_pkg::*;
#(
  parameter int NUM_DIGITS       = NUM_DIGITS_DEF,
  parameter int DIGIT_BITS       = DIGIT_BITS_DEF,
  parameter int REDUN_BITS       = REDUN_BITS_DEF,
  parameter int DIGITS_PER_CYCLE = DPC_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_DIGITS-1:0][REDUN_BITS-1:0] C,
  input  logic [NUM_DIGITS-1:0][REDUN_BITS-1:0] S,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] out_digits,
  output logic [CARRY_BITS-1:0]                 out_carry
);

  localparam int DPC        = DIGITS_PER_CYCLE;
  localparam int NUM_CHUNKS = NUM_DIGITS / DPC;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

  state_t state, state_n;

  logic [CW-1:0]         cnt;
  logic [CARRY_BITS-1:0] carry;
  logic [IW-1:0]         base;

  logic [NUM_DIGITS-1:0][REDUN_BITS-1:0] c_reg;
  logic [NUM_DIGITS-1:0][REDUN_BITS-1:0] s_reg;

  logic [DPC-1:0][REDUN_BITS-1:0] chunk_c;
  logic [DPC-1:0][REDUN_BITS-1:0] chunk_s;
  logic [DPC-1:0][DIGIT_BITS-1:0] res;
  logic [CARRY_BITS-1:0]          carry_next;

  always_comb begin
    base    = IW'(cnt) * IW'(DPC);
    chunk_c = '0;
    chunk_s = '0;
    for (int i = 0; i < DPC; i++) begin
      chunk_c[i] = c_reg[base + IW'(i)];
      chunk_s[i] = s_reg[base + IW'(i)];
    end
  end

  carry_resolve_chunk #(
    .DPC        (DPC),
    .DIGIT_BITS (DIGIT_BITS),
    .REDUN_BITS (REDUN_BITS)
  ) u_chunk (
    .c         (chunk_c),
    .s         (chunk_s),
    .carry_in  (carry),
    .digits    (res),
    .carry_out (carry_next)
  );

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= '0;
      out_digits <= '0;
      out_carry  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        cnt   <= '0;
        carry <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < DPC; i++)
          out_digits[base + IW'(i)] <= res[i];
        carry <= carry_next;
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) out_carry <= carry_next;
      end
    end
  end

  // Operand capture needs no reset: it is only read after an accept.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && in_valid) begin
      c_reg <= C;
      s_reg <= S;
    end
  end

endmodule

// File: tb/tb_redundant_normalizer.sv
// Scoreboard bench for redundant_normalizer at default parameters.
// Directed operands with hand-computed digit results and latency checks.
module tb_redundant_normalizer;

  localparam int N  = 130;
  localparam int DB = 16;
  localparam int RB = 19;

  typedef logic [N-1:0][RB-1:0] red_t;
  typedef logic [N-1:0][DB-1:0] dig_t;
  typedef struct packed {
    dig_t       d;
    logic [4:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  red_t       C;
  red_t       S;
  logic       out_valid;
  logic       out_ready;
  dig_t       out_digits;
  logic [4:0] out_carry;

  redundant_normalizer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .C          (C),
    .S          (S),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input dig_t act,
                         input dig_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < N; i++) begin
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: digit[%0d] got %h expected %h",
                   name, i, act[i], exp[i]);
          break;
        end
      end
    end
  endtask

  function automatic red_t fill(input logic [RB-1:0] v);
    red_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  // Cycle count and accept-edge timestamp.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) acc_cyc = cyc;
  end

  // Monitor: latency on each out_valid rise, result compare on handshake.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: out_valid with no operand pending");
        end else begin
          chk("latency", cyc - acc_cyc, 13);
        end
      end
      seen = out_valid;
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk_vec("digits", out_digits, e.d);
        chk("out_carry", out_carry, e.c);
      end
    end
  end

  task automatic issue(input red_t c, input red_t s, input exp_t e,
                       input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    in_valid = 1'b1;
    C = c;
    S = s;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    C = fill(19'h5A5A5);
    S = fill(19'h2C3C3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    red_t c, s;
    exp_t e, e2;
    dig_t snap_d;
    logic [4:0] snap_c;
    int n;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    C = '0;
    S = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk_vec("rst_digits", out_digits, '0);
    chk("rst_carry", out_carry, 0);

    // All zero.
    e = '0;
    issue('0, '0, e, 1);
    drain();

    // Single digit-0 pair 0x7FFFF + 0x7FFFF = 0xFFFFE.
    c = '0; s = '0;
    c[0] = 19'h7FFFF; s[0] = 19'h7FFFF;
    e = '0;
    e.d[0] = 16'hFFFE; e.d[1] = 16'h000F;
    issue(c, s, e, 1);
    drain();

    // Full-length ripple through every chunk.
    c = fill(19'h0FFFF); s = '0; s[0] = 19'h1;
    e = '0; e.c = 5'd1;
    issue(c, s, e, 1);
    drain();

    // Maximum operand everywhere.
    c = fill(19'h7FFFF);
    e.d = '0;
    for (int i = 2; i < N; i++) e.d[i] = 16'h000E;
    e.d[0] = 16'hFFFE; e.d[1] = 16'h000D; e.c = 5'd16;
    issue(c, c, e, 1);
    drain();

    // Backpressure in DONE with ignored in_valid pulses.
    out_ready = 1'b0;
    c = '0; s = '0;
    c[0] = 19'h7FFFF; s[0] = 19'h7FFFF;
    e = '0;
    e.d[0] = 16'hFFFE; e.d[1] = 16'h000F;
    issue(c, s, e, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_valid_seen", out_valid, 1);
    snap_d = out_digits;
    snap_c = out_carry;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      C = fill(19'h12345);
      S = fill(19'h00001);
      @(posedge clk); #1;
      chk_vec("hold_digits", out_digits, snap_d);
      chk("hold_carry", out_carry, snap_c);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_vec("idle_keeps_digits", out_digits, e.d);
    chk("idle_keeps_carry", out_carry, e.c);

    // Carry across a chunk boundary plus top-digit carry out.
    c = '0; s = '0;
    c[9] = 19'h1FFFF; s[9] = 19'h00001;
    c[129] = 19'h7FFFF; s[129] = 19'h7FFFF;
    e = '0;
    e.d[10] = 16'h0002; e.d[129] = 16'hFFFE; e.c = 5'd15;
    issue(c, s, e, 1);
    drain();

    // Reset while RUN is processing chunk 6.
    c = fill(19'h7FFFF);
    issue(c, c, e, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk_vec("abort_digits", out_digits, '0);
    chk("abort_carry", out_carry, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 0);

    c = fill(19'h0FFFF); s = '0; s[0] = 19'h1;
    e2 = '0; e2.c = 5'd1;
    issue(c, s, e2, 1);
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
